spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
Parameterised SPI master that replaces the fixed two-sensor (gyro/accel) SPI interface.
- Drives NUM_SLAVES active-low selects from one shared SCLK/MOSI pair and muxes the matching MISO.
- Supports all four CPOL/CPHA modes, a configurable SCLK divider and multi-word full-duplex transactions.
- Sits between the sensor-polling controller and the IMU pins; runs on div_clk.

Parameters:
NUM_SLAVES, 2, number of slave-select / MISO lines (index 0 = gyro, 1 = accel)
SEL_W, 1, width of slave_select; must satisfy 2^SEL_W >= NUM_SLAVES
DATA_W, 8, bits per word, shifted MSB first
CNT_W, 3, width of write_count_bytes; max words per transaction = 2^CNT_W-1
CLK_DIV, 1, SCLK half-period H in div_clk cycles (>=1)

Ports:
div_clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
slave_select  in  SEL_W  target slave index, sampled with write_start
cpol  in  1  SCLK idle level, sampled with write_start
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled with write_start
write_start  in  1  1-cycle request to start a transaction
write_data  in  DATA_W  word to transmit; see sampling rules below
write_count_bytes  in  CNT_W  number of words in the transaction
write_ready  out  1  high when idle and able to accept write_start
write_next  out  1  1-cycle pulse requesting the next tx word
read_ready  out  1  1-cycle pulse; read_data is valid in this cycle
read_data  out  DATA_W  last received word; held until the next read_ready
SCLK  out  1  SPI clock
MOSI  out  1  SPI data out
MISO  in  NUM_SLAVES  SPI data in, one line per slave
SS_N  out  NUM_SLAVES  active-low slave selects

Behaviour:
Reset values:
- write_ready=1, write_next=0, read_ready=0, read_data=0.
- SCLK=0, MOSI=0, SS_N=all 1s.
- Latched cpol/cpha/select = 0; state = IDLE.
- Reset mid-transaction aborts immediately: SS_N all 1s next cycle, no read_ready pulse.

FSM IDLE -> SETUP -> SHIFT -> HOLD -> GUARD -> IDLE:
- IDLE: write_ready=1; SCLK = latched cpol.
  - write_start=1 with write_count_bytes != 0 and slave_select < NUM_SLAVES: latch select, cpol, cpha, count and write_data (word 0); go to SETUP.
  - Otherwise write_start is ignored and write_ready stays 1.
- SETUP (H cycles): SS_N[sel]=0 from the first cycle after write_start; write_ready=0.
  - CPHA=0: MOSI = word0 MSB from the first SETUP cycle.
- SHIFT: SCLK toggles every H cycles; 2*DATA_W edges per word; words are back-to-back with no gap.
  - CPHA=0: sample MISO[sel] on odd edges, shift MOSI on even edges. The last (even) edge of a non-final word drives the next word's MSB.
  - CPHA=1: shift MOSI on odd edges, sample on even edges.
  - write_next pulses on the cycle of word k's 2nd edge, for k < count-1 only.
  - write_data is captured as word k+1 on the cycle of word k's final edge. The host must hold it stable from the cycle after write_next through that edge; no stall or backpressure exists.
  - read_ready pulses the cycle after each word's final edge, with read_data = the full DATA_W word.
- HOLD (H cycles after the final edge of the last word): SCLK at cpol; SS_N[sel] kept 0.
- GUARD (H cycles): SS_N all 1s, write_ready=0. write_ready returns to 1 on entry to IDLE.
- Timing (CLK_DIV=1): duration from write_start to SS_N rise = 1 + H + 2*DATA_W*H*count + H cycles.

Boundary conditions:
- write_start while busy: ignored; the in-flight transaction is unaffected.
- slave_select, cpol and cpha changes mid-transaction: ignored (latched values are used).
- Word counter compares against the latched count; count = 2^CNT_W-1 runs to completion with no wrap.
- Non-selected MISO lines are never sampled.
- SCLK never glitches: only one toggle per H cycles, and only in SHIFT.

Test Plan:
- Mode 0, CLK_DIV=1, slave 0, write_data=0xAA, count=2; MISO[0] = 1,0,1,0,1,... per sample edge:
  - SS_N[0] low cycles 1..34; MOSI word 0 = 10101010.
  - read_ready at cycles 18 and 34; read_data=0xAA then 0xAA.
  - write_next once, at cycle 3; SS_N[1] stays 1.
- Mode 3 (cpol=1, cpha=1), slave 1, write_data=0xFF, count=5:
  - SCLK idles 1 and returns to 1 in HOLD.
  - Exactly 5 read_ready pulses and 4 write_next pulses; 80 SCLK edges.
  - SS_N[0] stays 1 throughout.
- CLK_DIV=3, mode 1, count=1, tx=0x5A, MISO constant 1:
  - SCLK period is 6 cycles; MOSI sequence 01011010.
  - read_data=0xFF; write_ready is low for exactly 1+3+48+3+3 cycles.
- write_start pulsed mid-transaction with different data/select: no effect on SS_N, MOSI or the read_ready count.
- count=0 request, or slave_select >= NUM_SLAVES: SS_N stays all 1s, write_ready stays 1, SCLK does not toggle.
- Reset asserted during word 1 of a 3-word transfer:
  - Next cycle SS_N all 1s, SCLK=0, write_ready=1, read_data=0.
  - A subsequent transaction completes normally.

Source files
------------

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: shared SCLK/MOSI, per-slave active-low selects, all CPOL/CPHA modes,
// SCLK half-period of CLK_DIV cycles, multi-word full-duplex transfers.
module spi_master_multi #(
    parameter int NUM_SLAVES = 2,
    parameter int SEL_W      = 1,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 3,
    parameter int CLK_DIV    = 1
) (
    input  logic                  i_div_clk,
    input  logic                  i_reset,
    input  logic [SEL_W-1:0]      i_slave_select,
    input  logic                  i_cpol,
    input  logic                  i_cpha,
    input  logic                  i_write_start,
    input  logic [DATA_W-1:0]     i_write_data,
    input  logic [CNT_W-1:0]      i_write_count_bytes,
    output logic                  o_write_ready,
    output logic                  o_write_next,
    output logic                  o_read_ready,
    output logic [DATA_W-1:0]     o_read_data,
    output logic                  o_SCLK,
    output logic                  o_MOSI,
    input  logic [NUM_SLAVES-1:0] i_MISO,
    output logic [NUM_SLAVES-1:0] o_SS_N
);
    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int E_W  = (DATA_W > 1) ? $clog2(2*DATA_W) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV-1);
    localparam logic [HC_W-1:0] HC_PRE  = HC_W'((CLK_DIV > 1) ? CLK_DIV-2 : 0);
    localparam logic [E_W-1:0]  E_LAST  = E_W'(2*DATA_W-1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GUARD} state_t;

    state_t              r_state;
    logic [HC_W-1:0]     r_hcnt;
    logic [E_W-1:0]      r_edge;
    logic [CNT_W-1:0]    r_word;
    logic [CNT_W-1:0]    r_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic                r_cpol;
    logic                r_cpha;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_SLAVES-1:0] r_ss_n;
    logic                r_write_ready;
    logic                r_write_next;
    logic                r_read_ready;
    logic [DATA_W-1:0]   r_read_data;

    logic                w_miso;
    logic                w_tick;
    logic                w_last_edge;
    logic                w_sample;
    logic                w_last_word;
    logic                w_start_ok;
    logic                w_pre_wn;
    logic [DATA_W-1:0]   w_rx_nx;

    always_comb begin
        w_miso = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (r_sel == SEL_W'(i)) w_miso = i_MISO[i];
    end

    assign w_tick      = (r_hcnt == HC_LAST);
    assign w_last_edge = (r_edge == E_LAST);
    // r_edge counts edges already done, so an even count means the next edge is odd-numbered
    assign w_sample    = (r_edge[0] == 1'b0) ^ r_cpha;
    assign w_last_word = (r_word == r_cnt - CNT_W'(1));
    assign w_start_ok  = i_write_start && r_write_ready && (r_state == S_IDLE) &&
                         (i_write_count_bytes != '0) && (32'(i_slave_select) < NUM_SLAVES);
    assign w_rx_nx     = w_sample ? {r_rx[DATA_W-2:0], w_miso} : r_rx;

    // write_next is registered, so it is armed one cycle ahead of the word's 2nd edge
    assign w_pre_wn = (r_state == S_SHIFT) && !w_last_word &&
                      ((CLK_DIV == 1) ? ((r_edge == '0) && w_tick)
                                      : ((r_edge == E_W'(1)) && (r_hcnt == HC_PRE)));

    always_ff @(posedge i_div_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_hcnt        <= '0;
            r_edge        <= '0;
            r_word        <= '0;
            r_cnt         <= '0;
            r_sel         <= '0;
            r_cpol        <= 1'b0;
            r_cpha        <= 1'b0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_sclk        <= 1'b0;
            r_mosi        <= 1'b0;
            r_ss_n        <= '1;
            r_write_ready <= 1'b1;
            r_write_next  <= 1'b0;
            r_read_ready  <= 1'b0;
            r_read_data   <= '0;
        end else begin
            r_write_next <= w_pre_wn;
            r_read_ready <= 1'b0;
            if (r_state != S_IDLE)
                r_hcnt <= w_tick ? '0 : r_hcnt + HC_W'(1);

            case (r_state)
                S_IDLE: begin
                    r_sclk <= r_cpol;
                    if (!r_write_ready) begin
                        r_write_ready <= 1'b1;
                    end else if (w_start_ok) begin
                        r_sel         <= i_slave_select;
                        r_cpol        <= i_cpol;
                        r_cpha        <= i_cpha;
                        r_cnt         <= i_write_count_bytes;
                        r_sclk        <= i_cpol;
                        r_mosi        <= i_write_data[DATA_W-1];
                        r_tx          <= i_cpha ? i_write_data : (i_write_data << 1);
                        r_ss_n        <= ~(NUM_SLAVES'(1) << i_slave_select);
                        r_write_ready <= 1'b0;
                        r_hcnt        <= '0;
                        r_edge        <= '0;
                        r_word        <= '0;
                        r_state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_tick) r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (w_sample) r_rx <= w_rx_nx;
                        if (!w_sample && !w_last_edge) begin
                            r_mosi <= r_tx[DATA_W-1];
                            r_tx   <= r_tx << 1;
                        end
                        if (w_last_edge) begin
                            r_edge       <= '0;
                            r_read_ready <= 1'b1;
                            r_read_data  <= w_rx_nx;
                            if (w_last_word) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_word <= r_word + CNT_W'(1);
                                r_tx   <= r_cpha ? i_write_data : (i_write_data << 1);
                                if (!r_cpha) r_mosi <= i_write_data[DATA_W-1];
                            end
                        end else begin
                            r_edge <= r_edge + E_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_ss_n  <= '1;
                        r_state <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (w_tick) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_write_ready = r_write_ready;
    assign o_write_next  = r_write_next;
    assign o_read_ready  = r_read_ready;
    assign o_read_data   = r_read_data;
    assign o_SCLK        = r_sclk;
    assign o_MOSI        = r_mosi;
    assign o_SS_N        = r_ss_n;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: two instances (H=1 / 2 slaves, H=3 / 3 slaves) checked against
// a slave-side model built from edge counts, word lists and expected cycle totals.
module tb_spi_master_multi;
    logic             clk;
    logic [1:0]       rst, wstart, cpol, cpha;
    logic [1:0][1:0]  sel;
    logic [1:0][7:0]  wdata;
    logic [1:0][2:0]  wcnt;
    logic [1:0][2:0]  miso;
    logic [1:0]       wr_o, wn_o, rr_o, sclk_o, mosi_o;
    logic [1:0][7:0]  rd_o;
    logic [1:0]       ss_a;
    logic [2:0]       ss_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] tx_w [8];
    logic [7:0] rx_w [8];

    spi_master_multi #(.NUM_SLAVES(2), .SEL_W(1), .DATA_W(8), .CNT_W(3), .CLK_DIV(1)) u_a (
        .i_div_clk(clk), .i_reset(rst[0]), .i_slave_select(sel[0][0:0]), .i_cpol(cpol[0]),
        .i_cpha(cpha[0]), .i_write_start(wstart[0]), .i_write_data(wdata[0]),
        .i_write_count_bytes(wcnt[0]), .o_write_ready(wr_o[0]), .o_write_next(wn_o[0]),
        .o_read_ready(rr_o[0]), .o_read_data(rd_o[0]), .o_SCLK(sclk_o[0]), .o_MOSI(mosi_o[0]),
        .i_MISO(miso[0][1:0]), .o_SS_N(ss_a));

    spi_master_multi #(.NUM_SLAVES(3), .SEL_W(2), .DATA_W(8), .CNT_W(3), .CLK_DIV(3)) u_b (
        .i_div_clk(clk), .i_reset(rst[1]), .i_slave_select(sel[1]), .i_cpol(cpol[1]),
        .i_cpha(cpha[1]), .i_write_start(wstart[1]), .i_write_data(wdata[1]),
        .i_write_count_bytes(wcnt[1]), .o_write_ready(wr_o[1]), .o_write_next(wn_o[1]),
        .o_read_ready(rr_o[1]), .o_read_data(rd_o[1]), .o_SCLK(sclk_o[1]), .o_MOSI(mosi_o[1]),
        .i_MISO(miso[1]), .o_SS_N(ss_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ss_of(input int d);
        return (d == 0) ? {1'b1, ss_a} : ss_b;
    endfunction

    // Runs one transaction, acting as host and as the selected slave, then scores it.
    task automatic run_txn(input int d, input int s, input bit pol, input bit pha,
                           input int cnt, input bit inject);
        int h, ns, tot, t, mi, wr_low, ss_low, ss_first, oth_low, edges, gap_bad, last_e;
        int nwn, wn_first, rr_first;
        logic sclk_p, sclk1;
        logic [2:0] ss;
        logic [7:0] cur, w8;
        bit done;
        logic [7:0] got_rx[$];
        bit mosi_got[$];
        h = (d == 0) ? 1 : 3;
        ns = (d == 0) ? 2 : 3;
        tot = 1 + 3*h + 16*h*cnt;
        @(negedge clk);
        miso[d] = 3'($urandom);
        miso[d][s] = rx_w[0][7];
        sel[d] = 2'(s); cpol[d] = pol; cpha[d] = pha; wcnt[d] = 3'(cnt);
        cur = tx_w[0]; wdata[d] = cur; wstart[d] = 1'b1;
        t = 0; mi = 0; wr_low = 0; ss_low = 0; ss_first = -1; oth_low = 0; edges = 0;
        gap_bad = 0; last_e = -1; nwn = 0; wn_first = -1; rr_first = -1; done = 0;
        sclk_p = 1'b0; sclk1 = 1'b0;
        while (!done && t < tot + 10) begin
            @(negedge clk);
            t++;
            wstart[d] = 1'b0;
            ss = ss_of(d);
            if (!wr_o[d]) wr_low++; else done = 1;
            if (ss[s] == 1'b0) begin
                ss_low++;
                if (ss_first < 0) ss_first = t;
            end
            for (int k = 0; k < 3; k++) if (k != s && ss[k] == 1'b0) oth_low++;
            if (t == 1) sclk1 = sclk_o[d];
            else if (sclk_o[d] != sclk_p) begin
                edges++;
                if (last_e >= 0 && t - last_e != h) gap_bad++;
                last_e = t;
                if ((((edges - 1) % 2) == 0) ^ pha) begin
                    mosi_got.push_back(mosi_o[d]);
                    mi++;
                    if (mi < 8*cnt) miso[d][s] = rx_w[mi/8][7 - mi%8];
                end
            end
            sclk_p = sclk_o[d];
            for (int k = 0; k < 3; k++) if (k != s) miso[d][k] = 1'($urandom);
            if (rr_o[d]) begin
                got_rx.push_back(rd_o[d]);
                if (rr_first < 0) rr_first = t;
            end
            if (wn_o[d]) begin
                nwn++;
                if (wn_first < 0) wn_first = t;
                if (nwn < cnt) cur = tx_w[nwn];
            end
            wdata[d] = cur;
            sel[d] = 2'(s); cpol[d] = pol; cpha[d] = pha;
            if (inject && t == 1 + 4*h) begin
                wstart[d] = 1'b1;
                sel[d] = 2'((s + 1) % ns); cpol[d] = ~pol; cpha[d] = ~pha;
                wdata[d] = ~cur;
            end
        end
        chk("done", 32'(done), 1);
        chk("wr_low", wr_low, tot);
        chk("ss_low", ss_low, 2*h + 16*h*cnt);
        chk("ss_first", ss_first, 1);
        chk("ss_other", oth_low, 0);
        chk("edges", edges, 16*cnt);
        chk("edge_gap", gap_bad, 0);
        chk("sclk_idle", 32'(sclk1), 32'(pol));
        chk("sclk_end", 32'(sclk_p), 32'(pol));
        chk("rr_first", rr_first, 1 + h + 16*h);
        chk("wn_n", nwn, cnt - 1);
        if (cnt > 1) chk("wn_first", wn_first, 3*h);
        chk("rx_n", got_rx.size(), cnt);
        for (int w = 0; w < cnt && w < got_rx.size(); w++) chk("rx_word", got_rx[w], rx_w[w]);
        chk("mosi_n", mosi_got.size(), 8*cnt);
        for (int w = 0; w < cnt && 8*w + 7 < mosi_got.size(); w++) begin
            for (int i = 0; i < 8; i++) w8[7-i] = mosi_got[8*w + i];
            chk("mosi_word", w8, tx_w[w]);
        end
    endtask

    task automatic bad_req(input int d, input int s, input int cnt);
        int bad;
        logic sc;
        @(negedge clk);
        sc = sclk_o[d];
        sel[d] = 2'(s); wcnt[d] = 3'(cnt); cpol[d] = ~sc; cpha[d] = 1'b0;
        wdata[d] = 8'hA5; wstart[d] = 1'b1;
        bad = 0;
        repeat (24) begin
            @(negedge clk);
            wstart[d] = 1'b0;
            if (ss_of(d) != 3'b111 || !wr_o[d] || sclk_o[d] != sc) bad++;
        end
        chk("bad_req", bad, 0);
    endtask

    task automatic reset_mid(input int d);
        int t;
        bit seen;
        @(negedge clk);
        sel[d] = 2'd0; cpol[d] = 1'b1; cpha[d] = 1'b1; wcnt[d] = 3'd3;
        wdata[d] = 8'h3C; wstart[d] = 1'b1;
        seen = 0; t = 0;
        while (!seen && t < 400) begin
            @(negedge clk);
            wstart[d] = 1'b0;
            t++;
            if (rr_o[d]) seen = 1;
        end
        chk("rst_wait", 32'(seen), 1);
        repeat (2) @(negedge clk);
        rst[d] = 1'b1;
        @(negedge clk);
        chk("rst_ssn", ss_of(d), 3'b111);
        chk("rst_sclk", 32'(sclk_o[d]), 0);
        chk("rst_wr", 32'(wr_o[d]), 1);
        chk("rst_rd", rd_o[d], 0);
        chk("rst_rr", 32'(rr_o[d]), 0);
        rst[d] = 1'b0;
    endtask

    task automatic rand_words(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            tx_w[i] = 8'($urandom);
            rx_w[i] = 8'($urandom);
        end
    endtask

    initial begin
        rst = 2'b11; wstart = '0; cpol = '0; cpha = '0; sel = '0;
        wdata = '0; wcnt = '0; miso = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_wr", 32'(wr_o[d]), 1);
            chk("reset_wn", 32'(wn_o[d]), 0);
            chk("reset_rr", 32'(rr_o[d]), 0);
            chk("reset_rd", rd_o[d], 0);
            chk("reset_sclk", 32'(sclk_o[d]), 0);
            chk("reset_mosi", 32'(mosi_o[d]), 0);
            chk("reset_ssn", ss_of(d), 3'b111);
        end
        rst = 2'b00;
        @(negedge clk);

        // mode 0, 0xAA x2, slave answers 1010...
        tx_w[0] = 8'hAA; tx_w[1] = 8'hAA; rx_w[0] = 8'hAA; rx_w[1] = 8'hAA;
        run_txn(0, 0, 1'b0, 1'b0, 2, 1'b0);
        // mode 3, slave 1, 0xFF x5
        for (int i = 0; i < 5; i++) begin tx_w[i] = 8'hFF; rx_w[i] = 8'($urandom); end
        run_txn(0, 1, 1'b1, 1'b1, 5, 1'b0);
        // H=3, mode 1, 0x5A, MISO all ones
        tx_w[0] = 8'h5A; rx_w[0] = 8'hFF;
        run_txn(1, $urandom_range(2), 1'b0, 1'b1, 1, 1'b0);

        // busy write_start, including maximum-length transfers
        rand_words(7);
        run_txn(0, 0, 1'b0, 1'b1, 7, 1'b1);
        rand_words(7);
        run_txn(1, 2, 1'b1, 1'b0, 7, 1'b1);

        bad_req(0, 1, 0);
        bad_req(1, 3, 2);
        bad_req(1, 0, 0);

        for (int d = 0; d < 2; d++) begin
            reset_mid(d);
            rand_words(3);
            run_txn(d, 0, 1'b0, 1'b0, 3, 1'b0);
        end

        for (int n = 0; n < 6; n++) begin
            for (int d = 0; d < 2; d++) begin
                int c;
                c = $urandom_range(1, 7);
                rand_words(c);
                run_txn(d, $urandom_range(d == 0 ? 1 : 2), 1'($urandom), 1'($urandom), c, n == 3);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
